mod_instruction_fetch: RTL and testbench

- Fetch stage that sits directly upstream of the combinational word-addressed instruction memory.
- Owns the program counter and drives the memory address, then captures the returned instruction into a registered IF/ID slot.
- Presents that slot to decode with a valid/ready handshake.
- Supports stall via backpressure, fetch enable/halt and branch redirect with flush.

---
 rtl/mod_instruction_fetch_pkg.sv | 16 +
 rtl/mod_instruction_fetch_if.sv | 42 ++++
 rtl/mod_if_id_reg.sv | 49 ++++
 rtl/mod_instruction_fetch.sv | 98 +++++++++
 tb/tb_mod_instruction_fetch.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mod_instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and the
// default widths / reset PC, which the instruction memory also uses.
package mod_instruction_fetch_pkg;

    // Fetch FSM: IDLE issues nothing, RUN issues one fetch per free slot
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // Defaults shared with the word-addressed instruction memory
    localparam int          DEF_ADDR_W   = 33;
    localparam int          DEF_INS_W    = 33;
    localparam logic [32:0] DEF_RESET_PC = 33'd0;

endpackage

// File: rtl/mod_instruction_fetch_if.sv
// Fetch-stage bus: memory address/data, control inputs and the IF/ID
// valid/ready slot towards decode. master = fetch stage, slave = environment.
interface mod_instruction_fetch_if
    import mod_instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INS_W  = DEF_INS_W
);
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] address;
    logic [INS_W-1:0]  instruction;
    logic              id_valid;
    logic              id_ready;
    logic [INS_W-1:0]  id_instruction;
    logic [ADDR_W-1:0] id_pc;

    modport master (
        input  fetch_en,
        input  redirect_valid,
        input  redirect_target,
        output address,
        input  instruction,
        output id_valid,
        input  id_ready,
        output id_instruction,
        output id_pc
    );

    modport slave (
        output fetch_en,
        output redirect_valid,
        output redirect_target,
        input  address,
        output instruction,
        input  id_valid,
        output id_ready,
        input  id_instruction,
        input  id_pc
    );
endinterface

// File: rtl/mod_if_id_reg.sv
// IF/ID pipeline slot: holds one fetched instruction and its PC, presented
// to decode with valid/ready. Flush beats load beats accept.
module mod_if_id_reg #(
    parameter int ADDR_W = 33,
    parameter int INS_W  = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic              i_ready,
    input  logic [INS_W-1:0]  i_instruction,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [INS_W-1:0]  o_instruction,
    output logic [ADDR_W-1:0] o_pc
);
    logic              r_valid;
    logic [INS_W-1:0]  r_instruction;
    logic [ADDR_W-1:0] r_pc;

    // Valid flag: flush clears, load sets, accept without load clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only changes on load; it is deliberately kept after accept/flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instruction <= '0;
            r_pc          <= '0;
        end else if (i_load && !i_flush) begin
            r_instruction <= i_instruction;
            r_pc          <= i_pc;
        end
    end

    assign o_valid       = r_valid;
    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;
endmodule

// File: rtl/mod_instruction_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// word-addressed instruction memory and fills the IF/ID slot.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count / flush_count.
module mod_instruction_fetch
    import mod_instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INS_W    = DEF_INS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic clk,
    input  logic reset,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count,
`endif
    mod_instruction_fetch_if.master bus
);
    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic              w_slot_free;
    logic              w_fetch;
    logic              w_flush;

    // Next state follows fetch_en; redirect has no effect on the FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.fetch_en)  w_state_next = ST_RUN;
            ST_RUN:  if (!bus.fetch_en) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // A redirect discards the slot and suppresses the fetch in the same cycle
    assign w_slot_free = !bus.id_valid || bus.id_ready;
    assign w_flush     = bus.redirect_valid;
    assign w_fetch     = (r_state == ST_RUN) && bus.fetch_en && w_slot_free
                         && !bus.redirect_valid;

    // PC: redirect wins, otherwise step by one word on fetch (wraps silently)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc <= bus.redirect_target;
        end else if (w_fetch) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign bus.address = r_pc;

    mod_if_id_reg #(
        .ADDR_W (ADDR_W),
        .INS_W  (INS_W)
    ) u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_fetch),
        .i_flush       (w_flush),
        .i_ready       (bus.id_ready),
        .i_instruction (bus.instruction),
        .i_pc          (r_pc),
        .o_valid       (bus.id_valid),
        .o_instruction (bus.id_instruction),
        .o_pc          (bus.id_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    // Counters: every issued fetch, and every redirect that kills a valid slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_fetch)
                r_fetch_count <= r_fetch_count + 32'd1;
            if (bus.redirect_valid && bus.id_valid)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Directed bench for mod_instruction_fetch. Memory model: mem[a] = a + 100.
// Build with FETCH_PERF_CNT_EN defined to also check the perf counters.
module tb_mod_instruction_fetch;
    localparam int AW = 33;
    localparam int IW = 33;
    localparam logic [AW-1:0] PC_MAX = {AW{1'b1}};

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    mod_instruction_fetch_if #(.ADDR_W(AW), .INS_W(IW)) ifc ();

    // Combinational word-addressed memory: contents are address + 100
    assign ifc.instruction = ifc.address + 33'd100;

    mod_instruction_fetch #(.ADDR_W(AW), .INS_W(IW), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
        .flush_count (flush_count),
`endif
        .bus         (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [63:0] ins,
                            input logic [63:0] pc, input logic [63:0] addr);
        chk({tag, ".valid"}, 64'(ifc.id_valid), 64'(v));
        chk({tag, ".ins"},   64'(ifc.id_instruction), ins);
        chk({tag, ".pc"},    64'(ifc.id_pc), pc);
        chk({tag, ".addr"},  64'(ifc.address), addr);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        ifc.fetch_en        = 1'b0;
        ifc.redirect_valid  = 1'b0;
        ifc.redirect_target = '0;
        ifc.id_ready        = 1'b0;
        #12;
        chk_slot("reset", 1'b0, 0, 0, 0);
        reset = 1'b0;

        // Sequential stream: one cycle IDLE->RUN, then one fetch per cycle
        ifc.fetch_en = 1'b1;
        ifc.id_ready = 1'b1;
        tick();
        chk("run_entry.valid", 64'(ifc.id_valid), 0);
        chk("run_entry.addr",  64'(ifc.address), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_slot($sformatf("seq%0d", i), 1'b1, 64'(i + 100), 64'(i), 64'(i + 1));
        end

        // Backpressure: slot holds pc 5 for three cycles
        ifc.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_slot($sformatf("stall%0d", i), 1'b1, 105, 5, 6);
        end
        ifc.id_ready = 1'b1;
        tick();
        chk_slot("release", 1'b1, 106, 6, 7);

        // Redirect to 0x40 while the slot is valid and stalled
        ifc.id_ready = 1'b0;
        tick();
        chk_slot("stall_pre_redir", 1'b1, 106, 6, 7);
        ifc.redirect_valid  = 1'b1;
        ifc.redirect_target = 33'h40;
        tick();
        chk_slot("redir_flush", 1'b0, 106, 6, 64'h40);
        ifc.redirect_valid = 1'b0;
        ifc.id_ready       = 1'b1;
        tick();
        chk_slot("redir_first", 1'b1, 64'h40 + 100, 64'h40, 64'h41);

        // Wrap: redirect to the top address (slot valid, so this flushes too)
        ifc.redirect_valid  = 1'b1;
        ifc.redirect_target = PC_MAX;
        tick();
        chk_slot("wrap_redir", 1'b0, 64'h40 + 100, 64'h40, 64'(PC_MAX));
        ifc.redirect_valid = 1'b0;
        tick();
        chk_slot("wrap_fetch", 1'b1, 99, 64'(PC_MAX), 0);

        // fetch_en dropped with a valid slot: held until accepted, pc frozen
        ifc.id_ready = 1'b0;
        ifc.fetch_en = 1'b0;
        tick();
        chk_slot("halt_hold0", 1'b1, 99, 64'(PC_MAX), 0);
        tick();
        chk_slot("halt_hold1", 1'b1, 99, 64'(PC_MAX), 0);
        ifc.id_ready = 1'b1;
        tick();
        chk_slot("halt_accept", 1'b0, 99, 64'(PC_MAX), 0);
        tick();
        chk_slot("halt_idle", 1'b0, 99, 64'(PC_MAX), 0);
        ifc.fetch_en = 1'b1;
        tick();
        chk_slot("resume_run", 1'b0, 99, 64'(PC_MAX), 0);
        tick();
        chk_slot("resume_fetch", 1'b1, 100, 0, 1);

`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", 64'(fetch_count), 10);
        chk("flush_count", 64'(flush_count), 2);
`endif

        // Asynchronous reset between edges takes effect immediately
        #2;
        reset = 1'b1;
        #1;
        chk_slot("async_reset", 1'b0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_count", 64'(fetch_count), 0);
        chk("rst_flush_count", 64'(flush_count), 0);
`endif
        tick();
        chk_slot("reset_held", 1'b0, 0, 0, 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
